// File: rtl/module_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// a prediction pipe F->D->E, and Execute-stage training and recovery.
module module_branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pcf_i,
    input  logic        stalld_i,
    input  logic        flushd_i,
    input  logic        flushe_i,
    input  logic        branche_i,
    input  logic        pcsrce_i,
    input  logic [31:0] pctargete_i,
    input  logic [31:0] pcplus4e_i,
    output logic        predtakenf_o,
    output logic [31:0] predtargetf_o,
    output logic        prediction_bit_e_o,
    output logic        mispredicte_o,
    output logic [31:0] recoverypce_o
);

    localparam int DEPTH = 32'sd1 << INDEX_BITS;
    localparam int TAG_W = 32'sd30 - INDEX_BITS;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
            else              res = ctr;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
            else              res = ctr;
        end
        return res;
    endfunction

    logic                  valid_r  [DEPTH];
    logic [TAG_W-1:0]      tag_r    [DEPTH];
    logic [31:0]           target_r [DEPTH];
    logic [1:0]            ctr_r    [DEPTH];

    logic                  pred_d_r, valid_d_r, pred_e_r, valid_e_r;
    logic [INDEX_BITS-1:0] idx_d_r, idx_e_r;

    logic [INDEX_BITS-1:0] idx_f_s;
    logic [TAG_W-1:0]      tag_f_s, tag_e_s;
    logic [31:0]           br_pc_s;
    logic                  hit_s, upd_s;
    logic                  unused_bits_s;

    assign idx_f_s = pcf_i[INDEX_BITS+1:2];
    assign tag_f_s = pcf_i[31:INDEX_BITS+2];
    // The branch's own PC is recovered from PC+4 so the tag can be written in E.
    assign br_pc_s = pcplus4e_i - 32'd4;
    assign tag_e_s = br_pc_s[31:INDEX_BITS+2];
    assign upd_s   = branche_i & valid_e_r;
    assign unused_bits_s = ^{pcf_i[1:0], br_pc_s[INDEX_BITS+1:0]};

    // Fetch lookup and Execute resolution outputs.
    always_comb begin
        hit_s              = valid_r[idx_f_s] && (tag_r[idx_f_s] == tag_f_s);
        predtakenf_o       = hit_s & ctr_r[idx_f_s][1];
        predtargetf_o      = target_r[idx_f_s];
        prediction_bit_e_o = pred_e_r;
        mispredicte_o      = upd_s & (pcsrce_i ^ pred_e_r);
        if (pcsrce_i) recoverypce_o = pctargete_i;
        else          recoverypce_o = pcplus4e_i;
    end

    // D and E prediction registers; flush beats stall in D, E only bubbles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_d_r  <= 1'b0;
            idx_d_r   <= {INDEX_BITS{1'b0}};
            valid_d_r <= 1'b0;
            pred_e_r  <= 1'b0;
            idx_e_r   <= {INDEX_BITS{1'b0}};
            valid_e_r <= 1'b0;
        end else begin
            if (flushd_i) begin
                pred_d_r  <= 1'b0;
                idx_d_r   <= {INDEX_BITS{1'b0}};
                valid_d_r <= 1'b0;
            end else if (!stalld_i) begin
                pred_d_r  <= predtakenf_o;
                idx_d_r   <= idx_f_s;
                valid_d_r <= 1'b1;
            end
            if (flushe_i) begin
                pred_e_r  <= 1'b0;
                idx_e_r   <= {INDEX_BITS{1'b0}};
                valid_e_r <= 1'b0;
            end else begin
                pred_e_r  <= pred_d_r;
                idx_e_r   <= idx_d_r;
                valid_e_r <= valid_d_r;
            end
        end
    end

    // Table training; a taken resolution claims the entry even if another branch aliased it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= 32'd0;
                ctr_r[i]    <= 2'b01;
            end
        end else if (upd_s) begin
            ctr_r[idx_e_r] <= ctr_next(ctr_r[idx_e_r], pcsrce_i);
            if (pcsrce_i) begin
                valid_r[idx_e_r]  <= 1'b1;
                tag_r[idx_e_r]    <= tag_e_s;
                target_r[idx_e_r] <= pctargete_i;
            end
        end
    end

endmodule

// File: tb/tb_module_branch_predictor.sv
// Directed bench for module_branch_predictor with hand-computed expectations.
module tb_module_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] pcf_i;
    logic        stalld_i, flushd_i, flushe_i, branche_i, pcsrce_i;
    logic [31:0] pctargete_i, pcplus4e_i;
    logic        predtakenf_o;
    logic [31:0] predtargetf_o;
    logic        prediction_bit_e_o, mispredicte_o;
    logic [31:0] recoverypce_o;

    int checks = 0;
    int errors = 0;

    module_branch_predictor #(.INDEX_BITS(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pcf_i(pcf_i),
        .stalld_i(stalld_i), .flushd_i(flushd_i), .flushe_i(flushe_i),
        .branche_i(branche_i), .pcsrce_i(pcsrce_i),
        .pctargete_i(pctargete_i), .pcplus4e_i(pcplus4e_i),
        .predtakenf_o(predtakenf_o), .predtargetf_o(predtargetf_o),
        .prediction_bit_e_o(prediction_bit_e_o), .mispredicte_o(mispredicte_o),
        .recoverypce_o(recoverypce_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Fetch pc, let it reach E, then resolve it there.
    task automatic fetch_and_resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                     input logic exp_pred, input logic exp_mis, input logic [31:0] exp_rec);
        pcf_i = pc; #1;
        checks++; if (predtakenf_o !== exp_pred) begin errors++; $display("FAIL fr_predtakenf pc=%h: got %b exp %b", pc, predtakenf_o, exp_pred); end
        tick();
        pcf_i = 32'h0;
        tick();
        branche_i = 1'b0; pcsrce_i = taken; pctargete_i = tgt; pcplus4e_i = pc + 32'd4; #1;
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL fr_nonbranch_mis pc=%h: got %b exp 0", pc, mispredicte_o); end
        branche_i = 1'b1; #1;
        checks++; if (prediction_bit_e_o !== exp_pred) begin errors++; $display("FAIL fr_pred_e pc=%h: got %b exp %b", pc, prediction_bit_e_o, exp_pred); end
        checks++; if (mispredicte_o !== exp_mis) begin errors++; $display("FAIL fr_mispredict pc=%h: got %b exp %b", pc, mispredicte_o, exp_mis); end
        checks++; if (recoverypce_o !== exp_rec) begin errors++; $display("FAIL fr_recovery pc=%h: got %h exp %h", pc, recoverypce_o, exp_rec); end
        tick();
        branche_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; pcf_i = 32'h0; stalld_i = 1'b0; flushd_i = 1'b0; flushe_i = 1'b0;
        branche_i = 1'b0; pcsrce_i = 1'b0; pctargete_i = 32'h0; pcplus4e_i = 32'h0;
        tick(); tick();
        rst_n_i = 1'b1;
        pcf_i = 32'h48; pcplus4e_i = 32'h1234; pctargete_i = 32'h5678; #1;
        checks++; if (predtakenf_o !== 1'b0) begin errors++; $display("FAIL rst_predtakenf: got %b exp 0", predtakenf_o); end
        checks++; if (predtargetf_o !== 32'h0) begin errors++; $display("FAIL rst_predtargetf: got %h exp 0", predtargetf_o); end
        checks++; if (prediction_bit_e_o !== 1'b0) begin errors++; $display("FAIL rst_pred_e: got %b exp 0", prediction_bit_e_o); end
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL rst_mispredict: got %b exp 0", mispredicte_o); end
        checks++; if (recoverypce_o !== 32'h1234) begin errors++; $display("FAIL rst_recovery_nt: got %h exp 1234", recoverypce_o); end
        pcsrce_i = 1'b1; #1;
        checks++; if (recoverypce_o !== 32'h5678) begin errors++; $display("FAIL rst_recovery_t: got %h exp 5678", recoverypce_o); end
        checks++; if (dut.ctr_r[2] !== 2'b01) begin errors++; $display("FAIL rst_ctr2: got %b exp 01", dut.ctr_r[2]); end
        pcsrce_i = 1'b0; pcf_i = 32'h0;
    endtask

    task automatic test_cold_miss();
        fetch_and_resolve(32'h48, 1'b1, 32'h20, 1'b0, 1'b1, 32'h20);
        checks++; if (dut.ctr_r[2] !== 2'b10) begin errors++; $display("FAIL cold_ctr: got %b exp 10", dut.ctr_r[2]); end
        pcf_i = 32'h48; #1;
        checks++; if (predtakenf_o !== 1'b1) begin errors++; $display("FAIL cold_predtaken: got %b exp 1", predtakenf_o); end
        checks++; if (predtargetf_o !== 32'h20) begin errors++; $display("FAIL cold_target: got %h exp 20", predtargetf_o); end
        pcf_i = 32'h0;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            fetch_and_resolve(32'h48, 1'b1, 32'h20, 1'b1, 1'b0, 32'h20);
            checks++; if (dut.ctr_r[2] !== 2'b11) begin errors++; $display("FAIL sat_ctr_up%0d: got %b exp 11", k, dut.ctr_r[2]); end
        end
        fetch_and_resolve(32'h48, 1'b0, 32'h20, 1'b1, 1'b1, 32'h4C);
        checks++; if (dut.ctr_r[2] !== 2'b10) begin errors++; $display("FAIL sat_ctr_down: got %b exp 10", dut.ctr_r[2]); end
        pcf_i = 32'h48; #1;
        checks++; if (predtakenf_o !== 1'b1) begin errors++; $display("FAIL sat_still_taken: got %b exp 1", predtakenf_o); end
        pcf_i = 32'h0;
    endtask

    task automatic test_load_use();
        pcf_i = 32'h48;
        tick();
        pcf_i = 32'h0; stalld_i = 1'b1; flushe_i = 1'b1;
        tick();
        stalld_i = 1'b0; flushe_i = 1'b0;
        branche_i = 1'b1; pcsrce_i = 1'b1; pctargete_i = 32'h20; pcplus4e_i = 32'h4C; #1;
        checks++; if (prediction_bit_e_o !== 1'b0) begin errors++; $display("FAIL lu_bubble_pred: got %b exp 0", prediction_bit_e_o); end
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL lu_bubble_mis: got %b exp 0", mispredicte_o); end
        tick();
        checks++; if (dut.ctr_r[0] !== 2'b01) begin errors++; $display("FAIL lu_no_update_ctr0: got %b exp 01", dut.ctr_r[0]); end
        checks++; if (dut.ctr_r[2] !== 2'b10) begin errors++; $display("FAIL lu_no_update_ctr2: got %b exp 10", dut.ctr_r[2]); end
        checks++; if (prediction_bit_e_o !== 1'b1) begin errors++; $display("FAIL lu_branch_in_e: got %b exp 1", prediction_bit_e_o); end
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL lu_branch_mis: got %b exp 0", mispredicte_o); end
        tick();
        branche_i = 1'b0;
        checks++; if (dut.ctr_r[2] !== 2'b11) begin errors++; $display("FAIL lu_train_ctr2: got %b exp 11", dut.ctr_r[2]); end
    endtask

    task automatic test_mispredict_flush();
        pcf_i = 32'h48;
        tick(); tick();
        checks++; if (prediction_bit_e_o !== 1'b1) begin errors++; $display("FAIL fl_pre_pred: got %b exp 1", prediction_bit_e_o); end
        flushd_i = 1'b1; flushe_i = 1'b1;
        tick();
        flushd_i = 1'b0; flushe_i = 1'b0; pcf_i = 32'h0;
        branche_i = 1'b1; pcsrce_i = 1'b0; pcplus4e_i = 32'h4C; #1;
        checks++; if (prediction_bit_e_o !== 1'b0) begin errors++; $display("FAIL fl_pred_e: got %b exp 0", prediction_bit_e_o); end
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL fl_mis_e: got %b exp 0", mispredicte_o); end
        tick();
        checks++; if (dut.ctr_r[2] !== 2'b11) begin errors++; $display("FAIL fl_ctr2_a: got %b exp 11", dut.ctr_r[2]); end
        checks++; if (prediction_bit_e_o !== 1'b0) begin errors++; $display("FAIL fl_pred_d: got %b exp 0", prediction_bit_e_o); end
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL fl_mis_d: got %b exp 0", mispredicte_o); end
        tick();
        branche_i = 1'b0;
        checks++; if (dut.ctr_r[2] !== 2'b11) begin errors++; $display("FAIL fl_ctr2_b: got %b exp 11", dut.ctr_r[2]); end
        checks++; if (dut.ctr_r[0] !== 2'b01) begin errors++; $display("FAIL fl_ctr0: got %b exp 01", dut.ctr_r[0]); end
    endtask

    task automatic test_alias();
        pcf_i = 32'h88; #1;
        checks++; if (predtakenf_o !== 1'b0) begin errors++; $display("FAIL al_first_miss: got %b exp 0", predtakenf_o); end
        tick(); tick();
        branche_i = 1'b1; pcsrce_i = 1'b1; pctargete_i = 32'h100; pcplus4e_i = 32'h8C; #1;
        checks++; if (mispredicte_o !== 1'b1) begin errors++; $display("FAIL al_mis: got %b exp 1", mispredicte_o); end
        checks++; if (recoverypce_o !== 32'h100) begin errors++; $display("FAIL al_recovery: got %h exp 100", recoverypce_o); end
        checks++; if (predtakenf_o !== 1'b0) begin errors++; $display("FAIL al_same_cycle_old: got %b exp 0", predtakenf_o); end
        tick();
        branche_i = 1'b0; #1;
        checks++; if (predtakenf_o !== 1'b1) begin errors++; $display("FAIL al_new_hit: got %b exp 1", predtakenf_o); end
        checks++; if (predtargetf_o !== 32'h100) begin errors++; $display("FAIL al_new_target: got %h exp 100", predtargetf_o); end
        pcf_i = 32'h48; #1;
        checks++; if (predtakenf_o !== 1'b0) begin errors++; $display("FAIL al_old_miss: got %b exp 0", predtakenf_o); end
        checks++; if (dut.ctr_r[2] !== 2'b11) begin errors++; $display("FAIL al_ctr_shared: got %b exp 11", dut.ctr_r[2]); end
        pcf_i = 32'h0;
    endtask

    task automatic test_async_reset();
        pcf_i = 32'h88;
        tick(); tick();
        checks++; if (prediction_bit_e_o !== 1'b1) begin errors++; $display("FAIL ar_pre_pred: got %b exp 1", prediction_bit_e_o); end
        #2;
        rst_n_i = 1'b0; branche_i = 1'b1; pcsrce_i = 1'b0; #1;
        checks++; if (predtakenf_o !== 1'b0) begin errors++; $display("FAIL ar_predtaken: got %b exp 0", predtakenf_o); end
        checks++; if (predtargetf_o !== 32'h0) begin errors++; $display("FAIL ar_target: got %h exp 0", predtargetf_o); end
        checks++; if (prediction_bit_e_o !== 1'b0) begin errors++; $display("FAIL ar_pred_e: got %b exp 0", prediction_bit_e_o); end
        checks++; if (mispredicte_o !== 1'b0) begin errors++; $display("FAIL ar_mis: got %b exp 0", mispredicte_o); end
        #1;
        rst_n_i = 1'b1; branche_i = 1'b0; #1;
        checks++; if (dut.ctr_r[2] !== 2'b01) begin errors++; $display("FAIL ar_ctr2: got %b exp 01", dut.ctr_r[2]); end
        checks++; if (predtakenf_o !== 1'b0) begin errors++; $display("FAIL ar_post_miss: got %b exp 0", predtakenf_o); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_saturation();
        test_load_use();
        test_mispredict_flush();
        test_alias();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/module_branch_predictor.md
# module_branch_predictor

Dynamic branch predictor for the RV32I five-stage pipeline. It looks up the fetch PC in a direct-mapped branch target buffer (BTB) and a table of 2-bit saturating counters, and supplies the predicted-taken flag and target to the PC-select logic in Fetch. The prediction travels down F→D→E alongside the instruction. It is presented in Execute as `prediction_bit_e_o`, the bit the hazard unit XORs with `pcsrce` to decide the D/E flush. In Execute the block also takes the resolved branch outcome, trains its tables, and supplies the recovery PC.

## Interface
Parameters:
- `INDEX_BITS`, default 4: log2 of the table depth (default 16 entries). The index is `pc[INDEX_BITS+1:2]`; the tag is `pc[31:INDEX_BITS+2]`.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_n_i`, input, 1: reset, asynchronous, active-low.
- `pcf_i`, input, 32: Fetch-stage PC.
- `stalld_i`, input, 1: hold the D-stage prediction register.
- `flushd_i`, input, 1: clear the D-stage prediction register.
- `flushe_i`, input, 1: clear the E-stage prediction register.
- `branche_i`, input, 1: the E-stage instruction is a conditional branch.
- `pcsrce_i`, input, 1: actual outcome in E (1 = taken).
- `pctargete_i`, input, 32: computed branch target in E.
- `pcplus4e_i`, input, 32: PC+4 of the E-stage instruction.
- `predtakenf_o`, output, 1: predict taken for `pcf_i`.
- `predtargetf_o`, output, 32: predicted target for `pcf_i`.
- `prediction_bit_e_o`, output, 1: prediction carried with the E-stage instruction.
- `mispredicte_o`, output, 1: valid E-stage branch whose prediction was wrong.
- `recoverypce_o`, output, 32: correct next PC on mispredict.

## Operation
Storage, all in flops with asynchronous reset:
- Per entry: `valid`, a tag, a 32-bit target, and a 2-bit counter.
- Reset values: valid = 0, tag = 0, target = 0, counter = 2'b01 (weakly not-taken).

Fetch lookup (combinational on `pcf_i`):
- hit = `valid[idx]` & (`tag[idx]` == tag(`pcf_i`)).
- `predtakenf_o` = hit & `counter[idx][1]`.
- `predtargetf_o` = `target[idx]`. This is don't-care when `predtakenf_o` = 0 but is always driven.

Pipeline registers:
- D stage holds {`pred_d`, `idx_d`, `valid_d`}.
  - `flushd_i` loads zeros; it has priority over `stalld_i`.
  - Otherwise `stalld_i` holds the register.
  - Otherwise it loads {`predtakenf_o`, idx(`pcf_i`), 1}.
- E stage holds {`pred_e`, `idx_e`, `valid_e`}.
  - `flushe_i` loads zeros.
  - Otherwise it loads the D-stage contents.
  - The E stage has no stall input. A load-use stall asserts `stalld_i` and `flushe_i` together; D holds and E receives a bubble.
- `prediction_bit_e_o` = `pred_e`.

Execute resolution (combinational):
- upd = `branche_i` & `valid_e`.
- `mispredicte_o` = upd & (`pcsrce_i` ^ `pred_e`).
- `recoverypce_o` = `pcsrce_i` ? `pctargete_i` : `pcplus4e_i`. It is always driven.

Training, at the clock edge when upd = 1, on entry `idx_e`:
- Counter states: 00 SN, 01 WN, 10 WT, 11 ST.
  - Taken increments, saturating at 11.
  - Not-taken decrements, saturating at 00.
- On taken, set valid, write the tag from `pcplus4e_i - 4`, and write target = `pctargete_i`.
- On not-taken, valid, tag and target are unchanged.
- Aliasing: a different branch mapping to the same index replaces the tag and target on its first taken resolution. The counter is shared and is not reset.

Boundary conditions:
- Same-cycle read and write of one entry: the Fetch lookup sees the pre-update value. The new value is visible on the next cycle.
- Both flush inputs together: both registers are cleared, and no training happens from the flushed instruction on later cycles.
- Non-branch instructions in E (`branche_i` = 0): no update, and `mispredicte_o` = 0.
- Reset asserted mid-operation: all storage and pipeline registers return to reset values immediately, regardless of the clock.

## Timing
- Outputs after reset: `predtakenf_o` = 0, `prediction_bit_e_o` = 0, `mispredicte_o` = 0, `predtargetf_o` = 0. `recoverypce_o` follows its inputs.
- Lookup latency: 0 cycles (combinational from `pcf_i`).
- Prediction-to-E latency: 2 cycles when there are no stalls or flushes.
- Training becomes visible to a lookup 1 cycle after the resolving edge.
- The critical path is the tag compare plus the counter MSB into the PC mux. Maximum table depth is 2^INDEX_BITS with INDEX_BITS ≤ 8.

## Test plan
1. **Cold miss.** After reset, a taken branch at 0x48 targets 0x20.
   - In E: `prediction_bit_e_o` = 0, `mispredicte_o` = 1, `recoverypce_o` = 0x20.
   - Entry 2 then has counter 10 and target 0x20.
   - The next fetch of 0x48 gives `predtakenf_o` = 1 and `predtargetf_o` = 0x20.
2. **Saturation.** Resolve the branch at 0x48 as taken four times: the counter stops at 11. Then one not-taken: counter 10, prediction still 1, `mispredicte_o` = 1 and `recoverypce_o` = 0x4C on that resolution.
3. **Load-use bubble.**
   - Assert `stalld_i` and `flushe_i` together for 1 cycle while a predicted-taken branch sits in D.
   - The cycle after the edge shows E bubbled (`prediction_bit_e_o` = 0, no update with `branche_i` = 1).
   - The branch reaches E one cycle later with `prediction_bit_e_o` = 1.
4. **Mispredict flush.** Assert `flushd_i` and `flushe_i`: the D and E predictions are zeroed, and subsequent `branche_i` pulses cause no counter change.
5. **Alias.** A branch at 0x48 is taken, then a branch at 0x88 (same index 2, different tag) is taken to 0x100. A fetch of 0x48 now misses (`predtakenf_o` = 0), and a fetch of 0x88 hits with target 0x100.
6. **Async reset mid-run.** Drop `rst_n_i` between clock edges: all outputs are zero immediately and the counters read 01 after release.
